// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Brief    : Writeback queue in front of the register file. Buffers up to
//            DEPTH {regsel, data} entries in strict FIFO order, issues one
//            register file write per cycle when drain_en permits, reports
//            pending writes to queried registers and flags dropped pushes.
// Revision : 1.0  initial release
// ============================================================================
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_write,
  input  logic [2:0]               in_regsel,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     drain_en,
  output logic                     write,
  output logic [2:0]               writeregsel,
  output logic [WIDTH-1:0]         writedata,
  input  logic [2:0]               chk1sel,
  input  logic [2:0]               chk2sel,
  output logic                     chk1busy,
  output logic                     chk2busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     err
);

  localparam int             c_ptr_w = $clog2(DEPTH);
  localparam int             c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [2:0]         r_sel  [DEPTH];
  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic               r_err;

  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_drop;
  logic w_busy1;
  logic w_busy2;

  // Handshake decode: a pop frees a slot in the same cycle, so a push into a
  // full queue is still accepted when the head is draining.
  always_comb begin
    w_pop    = drain_en & (r_count != '0);
    w_full   = (r_count == c_depth);
    w_accept = in_write & (~w_full | w_pop);
    w_drop   = in_write & w_full & ~w_pop;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop)    r_head <= r_head + c_ptr_one;
      if (w_accept) r_tail <= r_tail + c_ptr_one;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_err <= 1'b1;
    end
  end

  // Per-slot valid bits feed the busy lookup; when a full queue pushes and
  // pops the same slot, the refill (written last) keeps the slot valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (w_pop)    r_valid[r_head] <= 1'b0;
      if (w_accept) r_valid[r_tail] <= 1'b1;
    end
  end

  // Entry payload storage; no reset needed because valid bits qualify it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sel[r_tail]  <= in_regsel;
      r_data[r_tail] <= in_data;
    end
  end

  // Pending-write lookup over stored entries only (same-cycle push excluded).
  always_comb begin
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_sel[i] == chk1sel)) w_busy1 = 1'b1;
      if (r_valid[i] && (r_sel[i] == chk2sel)) w_busy2 = 1'b1;
    end
  end

  // Output drive: head entry presented directly, write qualified by pop.
  always_comb begin
    write       = w_pop;
    writeregsel = r_sel[r_head];
    writedata   = r_data[r_head];
    chk1busy    = w_busy1;
    chk2busy    = w_busy2;
    count       = r_count;
    full        = w_full;
    err         = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Brief    : Self-checking bench for wb_queue: queue-based reference model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 17;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             in_write;
  logic [2:0]       in_regsel;
  logic [WIDTH-1:0] in_data;
  logic             drain_en;
  logic             write;
  logic [2:0]       writeregsel;
  logic [WIDTH-1:0] writedata;
  logic [2:0]       chk1sel;
  logic [2:0]       chk2sel;
  logic             chk1busy;
  logic             chk2busy;
  logic [$clog2(DEPTH):0] count;
  logic             full;
  logic             err;

  int checks = 0;
  int passes = 0;

  entry_t m_q[$];
  logic   m_err;
  entry_t obs_log[$];

  wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_write(in_write), .in_regsel(in_regsel),
    .in_data(in_data), .drain_en(drain_en), .write(write),
    .writeregsel(writeregsel), .writedata(writedata), .chk1sel(chk1sel),
    .chk2sel(chk2sel), .chk1busy(chk1busy), .chk2busy(chk2busy),
    .count(count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model update at each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_err = 1'b0;
    end else begin
      automatic int  n      = m_q.size();
      automatic bit  pop    = drain_en && (n != 0);
      automatic bit  accept = in_write && ((n != DEPTH) || pop);
      automatic entry_t e;
      if (in_write && !accept) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (accept) begin
        e.sel  = in_regsel;
        e.data = in_data;
        m_q.push_back(e);
      end
    end
  end

  // Compare process: outputs settled mid-cycle, checked against the model.
  always @(negedge clk) begin
    automatic int n  = m_q.size();
    automatic bit ew = drain_en && (n != 0);
    automatic bit b1 = 1'b0;
    automatic bit b2 = 1'b0;
    automatic entry_t e;
    foreach (m_q[i]) begin
      if (m_q[i].sel == chk1sel) b1 = 1'b1;
      if (m_q[i].sel == chk2sel) b2 = 1'b1;
    end
    chk("model_count", 32'(count), 32'(n));
    chk("model_full", 32'(full), 32'(n == DEPTH));
    chk("model_write", 32'(write), 32'(ew));
    chk("model_err", 32'(err), 32'(m_err));
    chk("model_busy1", 32'(chk1busy), 32'(b1));
    chk("model_busy2", 32'(chk2busy), 32'(b2));
    if (ew) begin
      chk("model_wsel", 32'(writeregsel), 32'(m_q[0].sel));
      chk("model_wdata", 32'(writedata), 32'(m_q[0].data));
    end
    if (write === 1'b1) begin
      e.sel  = writeregsel;
      e.data = writedata;
      obs_log.push_back(e);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic w, input logic [2:0] s, input logic [WIDTH-1:0] d);
    in_write  = w;
    in_regsel = s;
    in_data   = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_push(1'b0, 3'd0, '0);
    drain_en = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_push(1'b0, 3'd0, '0);
    drain_en = 1'b0;
    chk1sel = 3'd0;
    chk2sel = 3'd0;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy1", 32'(chk1busy), 32'd0);

    // Single push, one-cycle latency, then drained.
    next_cycle();
    drain_en = 1'b1;
    set_push(1'b1, 3'd3, 17'h1ABCD);
    @(negedge clk);
    chk("nobypass_write", 32'(write), 32'd0);
    next_cycle();
    set_push(1'b0, 3'd0, '0);
    @(negedge clk);
    chk("single_write", 32'(write), 32'd1);
    chk("single_sel", 32'(writeregsel), 32'd3);
    chk("single_data", 32'(writedata), 32'h1ABCD);
    chk("single_count", 32'(count), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("single_count0", 32'(count), 32'd0);
    chk("single_write0", 32'(write), 32'd0);

    // Fill with drain held off, query busy, then overflow drop.
    next_cycle();
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_push(1'b1, 3'(i), 17'(i * 'h11));
      next_cycle();
    end
    set_push(1'b0, 3'd0, '0);
    chk1sel = 3'd2;
    chk2sel = 3'd5;
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_busy1", 32'(chk1busy), 32'd1);
    chk("fill_busy2", 32'(chk2busy), 32'd0);
    chk("fill_write", 32'(write), 32'd0);
    next_cycle();
    set_push(1'b1, 3'd6, 17'h1FFFF);
    next_cycle();
    set_push(1'b0, 3'd0, '0);
    chk2sel = 3'd6;
    @(negedge clk);
    chk("drop_err", 32'(err), 32'd1);
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_busy6", 32'(chk2busy), 32'd0);
    next_cycle();
    obs_log.delete();
    drain_en = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("drain_n", 32'(obs_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_log.size(); i++) begin
      chk("drain_sel", 32'(obs_log[i].sel), 32'(i + 1));
      chk("drain_data", 32'(obs_log[i].data), 32'((i + 1) * 'h11));
    end
    chk("err_sticky", 32'(err), 32'd1);

    // Full with simultaneous pop and push.
    next_cycle();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_push(1'b1, 3'(i), 17'(i * 'h11));
      next_cycle();
    end
    obs_log.delete();
    drain_en = 1'b1;
    set_push(1'b1, 3'd7, 17'h00077);
    next_cycle();
    set_push(1'b0, 3'd0, '0);
    drain_en = 1'b0;
    @(negedge clk);
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_err", 32'(err), 32'd0);
    next_cycle();
    drain_en = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("pp_n", 32'(obs_log.size()), 32'd5);
    if (obs_log.size() == 5) begin
      chk("pp_last_sel", 32'(obs_log[4].sel), 32'd7);
      chk("pp_last_data", 32'(obs_log[4].data), 32'h00077);
    end

    // Streaming push and pop: pointers wrap, count holds at 1.
    next_cycle();
    obs_log.delete();
    for (int i = 0; i < 10; i++) begin
      set_push(1'b1, 3'(i % 8), 17'('h100 + i));
      next_cycle();
      @(negedge clk);
      chk("stream_count", 32'(count), 32'd1);
      #1;
    end
    set_push(1'b0, 3'd0, '0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("stream_n", 32'(obs_log.size()), 32'd10);
    for (int i = 0; i < 10 && i < obs_log.size(); i++)
      chk("stream_data", 32'(obs_log[i].data), 32'('h100 + i));

    // Reset mid-operation with a colliding push.
    next_cycle();
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 3'(i + 1), 17'('h200 + i));
      next_cycle();
    end
    chk1sel = 3'd1;
    chk2sel = 3'd5;
    rst = 1'b1;
    set_push(1'b1, 3'd5, 17'h00555);
    drain_en = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_push(1'b0, 3'd0, '0);
    drain_en = 1'b0;
    @(negedge clk);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_write", 32'(write), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_busy1", 32'(chk1busy), 32'd0);
    chk("mrst_busy2", 32'(chk2busy), 32'd0);
    next_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued writeback entries; power of two, 2..8.
REQ-002 Parameter WIDTH, default 17, data width, matching the register file data path.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_write  input  1  push request from producer; no backpressure handshake.
REQ-006 in_regsel  input  3  destination register of pushed entry.
REQ-007 in_data  input  WIDTH  data of pushed entry.
REQ-008 drain_en  input  1  permission to issue one write to the register file this cycle.
REQ-009 write  output  1  register file write enable.
REQ-010 writeregsel  output  3  register file write select (head entry regsel).
REQ-011 writedata  output  WIDTH  register file write data (head entry data).
REQ-012 chk1sel, chk2sel  input  3 each  registers queried for pending writes.
REQ-013 chk1busy, chk2busy  output  1 each  queried register has a queued, undrained write.
REQ-014 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-015 full  output  1  count == DEPTH.
REQ-016 err  output  1  sticky overflow flag.

Function
REQ-017 Storage: circular buffer of DEPTH entries {regsel, data}; head and tail pointers wrap modulo DEPTH.
REQ-018 Pop condition: pop = drain_en & (count != 0).
REQ-019 write = pop, combinational; writeregsel/writedata = head entry, combinational; with count == 0, writeregsel/writedata don't-care, write = 0.
REQ-020 Push acceptance: accept = in_write & (!full | pop); accepted entry written at tail, tail advances next edge.
REQ-021 Dropped push (in_write & full & !pop): entry discarded; err set to 1 next edge, held until rst.
REQ-022 count next = count + accept - pop; push and pop same cycle leave count unchanged, pointers both advance.
REQ-023 Latency: entry accepted at edge N is earliest head and drainable in cycle after edge N; no same-cycle input-to-write bypass, even when empty.
REQ-024 Ordering: strict FIFO; multiple entries to same regsel allowed, drained in push order.
REQ-025 chkNbusy = OR over valid entries of (entry.regsel == chkNsel), combinational on stored state only; same-cycle push not included; head being popped this cycle still counts as busy.
REQ-026 Pointer wrap: after DEPTH pushes/pops, pointer returns to 0 with no loss or duplication.
REQ-027 drain_en low holds all entries and outputs stable; write = 0.

Reset
REQ-028 rst high at edge: count = 0, head = tail = 0, err = 0, all valid state cleared; entry data storage not reset.
REQ-029 Combinational consequence during/after reset: write = 0, full = 0, chk1busy = chk2busy = 0.
REQ-030 rst mid-operation discards all queued entries; rst has priority over simultaneous in_write and drain_en.

Verification
REQ-031 Reset, drain_en=1, push {3, 0x1ABCD} one cycle -> next cycle write=1, writeregsel=3, writedata=0x1ABCD, count=1; following cycle count=0, write=0.
REQ-032 drain_en=0, push regs 1,2,3,4 (data 0x11..0x44) -> full=1, count=4; chk1sel=2 -> chk1busy=1; chk2sel=5 -> chk2busy=0; then drain_en=1 -> writes 1,2,3,4 in order over 4 cycles.
REQ-033 Full, drain_en=0, push {6, 0x1FFFF} -> dropped, err=1 next cycle and stays 1; count remains 4; reg 6 never written.
REQ-034 Full, drain_en=1 with simultaneous push {7, 0x00077} -> accepted, count stays 4, err=0; {7, 0x00077} drained last.
REQ-035 10 push/pop cycles with drain_en=1 and in_write=1 -> pointers wrap twice, every entry emitted exactly once in order, count stable at 1.
REQ-036 Queue holding 3 entries, rst for one cycle with in_write=1 -> count=0, write=0, err=0, busy flags 0; pushed entry discarded.
